// File: rtl/sync_counter_pkg.sv
// Shared constants for the free-running loadable up-counter.
package sync_counter_pkg;

  // Default width of the count register, load input and count output.
  localparam int unsigned COUNT_WIDTH = 8;

  // All-ones terminal value for the default width.
  localparam logic [COUNT_WIDTH-1:0] TERMINAL_COUNT = {COUNT_WIDTH{1'b1}};

endpackage : sync_counter_pkg

// File: rtl/sync_counter.sv
// Free-running up-counter with synchronous parallel load and terminal-count decode.
// Priority per rising edge: rst > en (load) > increment; wraps modulo 2^WIDTH.
module sync_counter
  import sync_counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output logic             tcount
);

  localparam logic [WIDTH-1:0] TERM_VALUE = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next-state select: load has priority over increment; load is ignored when en=0.
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (en) begin
      count_d = load;
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  // Terminal flag depends only on the stored count, never on the inputs.
  assign tcount = (count_q == TERM_VALUE);

endmodule : sync_counter

// File: tb/tb_sync_counter.sv
// Self-checking bench for sync_counter against an arithmetic reference model.
module tb_sync_counter;
  import sync_counter_pkg::*;

  localparam int unsigned W    = COUNT_WIDTH;
  localparam int unsigned MODV = 1 << W;
  localparam int unsigned MAXV = MODV - 1;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] load;
  logic [W-1:0] count;
  logic         tcount;

  int unsigned  m_count;   // reference value of the counter
  int           n_checks;
  int           n_pass;

  sync_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .count  (count),
    .tcount (tcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, update the reference from the sampled inputs, then settle.
  task automatic tick();
    @(posedge clk);
    if (rst)     m_count = 0;
    else if (en) m_count = int'(load);
    else         m_count = (m_count + 1) % MODV;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = W'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (count !== W'(0) || tcount !== 1'b0)
        $display("FAIL reset[%0d] count=%0d tcount=%b expected count=0 tcount=0", i, count, tcount);
      else n_pass++;
    end
  endtask

  task automatic test_free_run();
    rst = 1'b0; en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (count !== W'(k) || tcount !== 1'b0)
        $display("FAIL free_run[%0d] count=%0d tcount=%b expected count=%0d tcount=0", k, count, tcount, k);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    en = 1'b1; load = W'(7);
    tick();
    n_checks++;
    if (count !== W'(7))
      $display("FAIL load count=%0d expected 7", count);
    else n_pass++;
    en = 1'b0; load = W'($urandom);
    for (int k = 8; k <= 10; k++) begin
      tick();
      n_checks++;
      if (count !== W'(k) || tcount !== 1'b0)
        $display("FAIL load_resume count=%0d tcount=%b expected count=%0d tcount=0", count, tcount, k);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int unsigned exp_seq [4];
    exp_seq[0] = MAXV - 1; exp_seq[1] = MAXV; exp_seq[2] = 0; exp_seq[3] = 1;
    en = 1'b1; load = W'(MAXV - 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      en = 1'b0;
      n_checks++;
      if (count !== W'(exp_seq[i]) || tcount !== (exp_seq[i] == MAXV))
        $display("FAIL wrap[%0d] count=%0d tcount=%b expected count=%0d tcount=%b",
                 i, count, tcount, exp_seq[i], (exp_seq[i] == MAXV));
      else n_pass++;
    end
  endtask

  task automatic test_hold_terminal();
    en = 1'b1; load = W'(MAXV);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count !== TERMINAL_COUNT || tcount !== 1'b1)
        $display("FAIL hold_terminal[%0d] count=%0d tcount=%b expected count=%0d tcount=1",
                 i, count, tcount, MAXV);
      else n_pass++;
    end
    // While en stays high the count follows a changing load value.
    for (int i = 0; i < 3; i++) begin
      load = W'($urandom_range(MAXV - 1, 0));
      tick();
      n_checks++;
      if (count !== load || tcount !== 1'b0)
        $display("FAIL load_follow[%0d] count=%0d tcount=%b expected count=%0d tcount=0",
                 i, count, tcount, load);
      else n_pass++;
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    rst = 1'b1; en = 1'b1; load = W'(8'hAA);
    tick();
    n_checks++;
    if (count !== W'(0) || tcount !== 1'b0)
      $display("FAIL priority count=%0d tcount=%b expected count=0 tcount=0", count, tcount);
    else n_pass++;
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (count !== W'(10))
      $display("FAIL pre_reset_mid count=%0d expected 10", count);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (count !== W'(0))
      $display("FAIL reset_mid count=%0d expected 0", count);
    else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks++;
      if (count !== W'(k))
        $display("FAIL reset_mid_resume count=%0d expected %0d", count, k);
      else n_pass++;
    end
  endtask

  task automatic test_load_x_ignored();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load = 'x;
      tick();
      n_checks++;
      if (count !== W'(m_count))
        $display("FAIL load_x count=%0d expected %0d", count, m_count);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(15, 0) == 0);
      en   = ($urandom_range(3, 0) == 0);
      // Bias loads toward the terminal neighbourhood to exercise the flag.
      load = ($urandom_range(1, 0) == 0) ? W'(MAXV - $urandom_range(2, 0)) : W'($urandom);
      tick();
      n_checks++;
      if (count !== W'(m_count) || tcount !== (m_count == MAXV))
        $display("FAIL random[%0d] count=%0d tcount=%b expected count=%0d tcount=%b",
                 i, count, tcount, m_count, (m_count == MAXV));
      else n_pass++;
    end
    rst = 1'b0; en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_count  = 0;
    rst = 1'b1; en = 1'b0; load = '0;
    test_reset();
    test_free_run();
    test_load();
    test_wrap();
    test_hold_terminal();
    test_priority();
    test_reset_mid();
    test_load_x_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t with %0d/%0d checks passed", $time, n_pass, n_checks);
    $fatal(1);
  end

endmodule : tb_sync_counter
